// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and
// a sizing helper for the settle down-counter.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        TTS_IDLE   = 2'd0,
        TTS_WAIT   = 2'd1,
        TTS_SAMPLE = 2'd2,
        TTS_DONE   = 2'd3
    } tts_state_e;

    // Width of a counter that must hold the value 'settle'. The result is at
    // least 1, so the counter still exists when no settling is configured.
    function automatic int tts_cnt_width(input int settle);
        int width;
        if (settle > 32'sd1) begin
            width = $clog2(settle + 32'sd1);
        end else begin
            width = 32'sd1;
        end
        return width;
    endfunction

endpackage

// File: rtl/tts_slice_cmp.sv
// Combinational check of the function outputs against the expected
// truth-table entry for the vector currently being swept.
module tts_slice_cmp #(
    parameter int N_IN  = 2,
    parameter int OUT_W = 2
) (
    input  logic [N_IN-1:0]              idx,
    input  logic [OUT_W-1:0]             fn_in,
    input  logic [(2**N_IN)*OUT_W-1:0]   exp_table,
    output logic                         mismatch
);

    logic [OUT_W-1:0] exp_slice_s;

    // Select the expected entry for vector idx and flag any differing bit.
    always_comb begin
        exp_slice_s = exp_table[idx*OUT_W +: OUT_W];
        mismatch    = (fn_in != exp_slice_s);
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked, self-checking sweep of every input vector into small
// combinational units: drives vec_out, waits SETTLE cycles, samples fn_in,
// records it and tallies mismatches against exp_table.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int OUT_W  = 2,
    parameter int SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    output logic [N_IN-1:0]              vec_out,
    input  logic [OUT_W-1:0]             fn_in,
    input  logic [(2**N_IN)*OUT_W-1:0]   exp_table,
    output logic [(2**N_IN)*OUT_W-1:0]   result_table,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [N_IN:0]                err_count,
    output logic [N_IN-1:0]              first_err_idx
);

    localparam int N_VEC = 2**N_IN;
    localparam int TBL_W = N_VEC * OUT_W;
    localparam int CNT_W = tts_cnt_width(SETTLE);

    localparam logic [N_IN-1:0]  LAST_IDX    = N_IN'(N_VEC - 1);
    localparam logic [N_IN-1:0]  IDX_ONE     = N_IN'(1'b1);
    localparam logic [N_IN:0]    ERR_ONE     = (N_IN + 1)'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE);
    // With no settling the next vector is sampled straight away.
    localparam tts_state_e AFTER_DRIVE = (SETTLE == 0) ? TTS_SAMPLE : TTS_WAIT;

    tts_state_e        state_r;
    tts_state_e        state_next_s;
    logic [N_IN-1:0]   idx_r;
    logic [N_IN-1:0]   idx_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [TBL_W-1:0]  result_r;
    logic [TBL_W-1:0]  result_next_s;
    logic [N_IN:0]     err_r;
    logic [N_IN:0]     err_next_s;
    logic [N_IN-1:0]   first_r;
    logic [N_IN-1:0]   first_next_s;
    logic              pass_r;
    logic              pass_next_s;
    logic              busy_r;
    logic              busy_next_s;
    logic              done_r;
    logic              done_next_s;
    logic              mismatch_s;

    tts_slice_cmp #(
        .N_IN  (N_IN),
        .OUT_W (OUT_W)
    ) u_cmp (
        .idx       (idx_r),
        .fn_in     (fn_in),
        .exp_table (exp_table),
        .mismatch  (mismatch_s)
    );

    // Next-state and next-result logic; busy/done are derived from the
    // next state so they come straight out of flops.
    always_comb begin
        state_next_s  = state_r;
        idx_next_s    = idx_r;
        cnt_next_s    = cnt_r;
        result_next_s = result_r;
        err_next_s    = err_r;
        first_next_s  = first_r;
        pass_next_s   = pass_r;

        case (state_r)
            TTS_IDLE: begin
                if (start) begin
                    result_next_s = {TBL_W{1'b0}};
                    err_next_s    = {(N_IN + 1){1'b0}};
                    first_next_s  = {N_IN{1'b0}};
                    pass_next_s   = 1'b0;
                    idx_next_s    = {N_IN{1'b0}};
                    cnt_next_s    = SETTLE_LOAD;
                    state_next_s  = AFTER_DRIVE;
                end else begin
                    state_next_s  = TTS_IDLE;
                end
            end
            TTS_WAIT: begin
                if (abort) begin
                    state_next_s = TTS_IDLE;
                end else if (cnt_r <= CNT_ONE) begin
                    state_next_s = TTS_SAMPLE;
                end else begin
                    cnt_next_s   = cnt_r - CNT_ONE;
                end
            end
            TTS_SAMPLE: begin
                if (abort) begin
                    state_next_s = TTS_IDLE;
                end else begin
                    result_next_s[idx_r*OUT_W +: OUT_W] = fn_in;
                    if (mismatch_s) begin
                        err_next_s = err_r + ERR_ONE;
                        if (err_r == {(N_IN + 1){1'b0}}) begin
                            first_next_s = idx_r;
                        end else begin
                            first_next_s = first_r;
                        end
                    end else begin
                        err_next_s = err_r;
                    end
                    if (idx_r == LAST_IDX) begin
                        // pass is published together with the done pulse.
                        pass_next_s  = (err_next_s == {(N_IN + 1){1'b0}});
                        state_next_s = TTS_DONE;
                    end else begin
                        idx_next_s   = idx_r + IDX_ONE;
                        cnt_next_s   = SETTLE_LOAD;
                        state_next_s = AFTER_DRIVE;
                    end
                end
            end
            TTS_DONE: begin
                state_next_s = TTS_IDLE;
            end
            default: begin
                state_next_s = TTS_IDLE;
            end
        endcase

        busy_next_s = (state_next_s == TTS_WAIT) || (state_next_s == TTS_SAMPLE);
        done_next_s = (state_next_s == TTS_DONE);
    end

    // State, counters and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= TTS_IDLE;
            idx_r    <= {N_IN{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {TBL_W{1'b0}};
            err_r    <= {(N_IN + 1){1'b0}};
            first_r  <= {N_IN{1'b0}};
            pass_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            idx_r    <= idx_next_s;
            cnt_r    <= cnt_next_s;
            result_r <= result_next_s;
            err_r    <= err_next_s;
            first_r  <= first_next_s;
            pass_r   <= pass_next_s;
            busy_r   <= busy_next_s;
            done_r   <= done_next_s;
        end
    end

    assign vec_out       = idx_r;
    assign result_table  = result_r;
    assign err_count     = err_r;
    assign first_err_idx = first_r;
    assign pass          = pass_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a SETTLE=1 instance checked every cycle
// against a cycle-count model, plus a SETTLE=0 instance on shared inputs
// for latency/result literals. Units under test: f5a = a&~b, f5b = a|~b.
module tb_truth_table_sweeper;

    localparam int M_S = 1;               // settle of the modelled instance
    localparam int T   = 4 * (M_S + 1);   // cycles from accept to done

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] exp_table;

    logic [1:0] v1, fe1, fn1, v0, fe0, fn0;
    logic [7:0] rt1, rt0;
    logic [2:0] ec1, ec0;
    logic       busy1, done1, pass1, busy0, done0, pass0;

    int n_chk = 0;
    int n_err = 0;

    // model state
    bit         m_active, m_done, m_pass;
    int         m_k, m_err, m_first, m_vec;
    logic [7:0] m_res;

    assign fn1 = {v1[1] | ~v1[0], v1[1] & ~v1[0]};
    assign fn0 = {v0[1] | ~v0[0], v0[1] & ~v0[0]};

    truth_table_sweeper #(.N_IN(2), .OUT_W(2), .SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .vec_out(v1), .fn_in(fn1), .exp_table(exp_table), .result_table(rt1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1), .first_err_idx(fe1)
    );

    truth_table_sweeper #(.N_IN(2), .OUT_W(2), .SETTLE(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .vec_out(v0), .fn_in(fn0), .exp_table(exp_table), .result_table(rt0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0), .first_err_idx(fe0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // What the two units must produce for vector v (a = MSB, b = LSB).
    function automatic logic [1:0] ref_fn(input int v);
        bit a, b;
        a = (v >= 2);
        b = ((v % 2) == 1);
        return {a || !b, a && !b};
    endfunction

    // Advance the model by one clock edge, from the inputs seen at that edge.
    task automatic model_step();
        int v;
        logic [1:0] got;
        if (reset) begin
            m_active = 0; m_done = 0; m_pass = 0;
            m_k = 0; m_err = 0; m_first = 0; m_vec = 0; m_res = 8'h00;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_k = 0; m_res = 8'h00;
                m_err = 0; m_first = 0; m_pass = 0; m_vec = 0;
            end
        end else if (abort) begin
            m_active = 0;
        end else begin
            if ((m_k % (M_S + 1)) == M_S) begin
                v = m_k / (M_S + 1);
                got = ref_fn(v);
                m_res[2*v +: 2] = got;
                if (got != exp_table[2*v +: 2]) begin
                    if (m_err == 0) m_first = v;
                    m_err++;
                end
            end
            m_k++;
            if (m_k == T) begin
                m_active = 0; m_done = 1; m_pass = (m_err == 0);
            end else begin
                m_vec = m_k / (M_S + 1);
            end
        end
    endtask

    // Per-cycle comparison of the SETTLE=1 instance against the model.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("busy", busy1, m_active);
            chk("done", done1, m_done);
            chk("pass", pass1, m_pass);
            chk("err_count", ec1, m_err);
            chk("first_err_idx", fe1, m_first);
            chk("vec_out", v1, m_vec);
            chk("result_table", rt1, m_res);
        end
    end

    // Pulse start for one cycle; report the done latency of both instances
    // and the vec_out sequence of the SETTLE=1 instance.
    task automatic run_sweep(output int lat1, output int lat0, output logic [15:0] seq);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat1 = -1; lat0 = -1; seq = 16'h0000;
        for (int n = 0; n < 40; n++) begin
            if (n < 8) seq = {seq[13:0], v1};
            if (done1 && lat1 < 0) lat1 = n;
            if (done0 && lat0 < 0) lat0 = n;
            if (lat1 >= 0 && lat0 >= 0) break;
            @(negedge clk);
        end
    endtask

    initial begin
        int l1, l0, c_le17, p1, p2, nd;
        logic [15:0] seq;
        reset = 1'b1; start = 1'b0; abort = 1'b0; exp_table = 8'hB2;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_busy", busy1, 32'd0);
        chk("rst_done", done1, 32'd0);
        chk("rst_pass", pass1, 32'd0);
        chk("rst_err", ec1, 32'd0);
        chk("rst_first", fe1, 32'd0);
        chk("rst_vec", v1, 32'd0);
        chk("rst_result", rt1, 32'd0);

        // 1: correct table
        run_sweep(l1, l0, seq);
        chk("t1_lat", l1, 32'd8);
        chk("t1_seq", seq, 32'h05AF);
        chk("t1_result", rt1, 32'hB2);
        chk("t1_err", ec1, 32'd0);
        chk("t1_pass", pass1, 32'd1);
        chk("t6_lat0", l0, 32'd4);
        chk("t6_result0", rt0, 32'hB2);
        chk("t6_err0", ec0, 32'd0);
        chk("t6_pass0", pass0, 32'd1);
        repeat (2) @(negedge clk);

        // 2: single wrong entries
        exp_table = 8'hB3;
        run_sweep(l1, l0, seq);
        chk("t2a_err", ec1, 32'd1);
        chk("t2a_first", fe1, 32'd0);
        chk("t2a_pass", pass1, 32'd0);
        repeat (2) @(negedge clk);
        exp_table = 8'h32;
        run_sweep(l1, l0, seq);
        chk("t2b_err", ec1, 32'd1);
        chk("t2b_first", fe1, 32'd3);
        chk("t2b_err0", ec0, 32'd1);
        chk("t2b_first0", fe0, 32'd3);
        repeat (2) @(negedge clk);
        exp_table = 8'hB2;

        // 3: start held high
        start = 1'b1;
        @(negedge clk);
        c_le17 = 0; p1 = -1; p2 = -1;
        for (int n = 0; n < 26; n++) begin
            if (done1) begin
                if (n <= 17) c_le17++;
                if (p1 < 0) p1 = n;
                else if (p2 < 0) p2 = n;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("t3_one_done", c_le17, 32'd1);
        chk("t3_first_done", p1, 32'd8);
        chk("t3_second_done", p2, 32'd18);
        repeat (12) @(negedge clk);

        // 4: abort during the second vector
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_busy", busy1, 32'd0);
        chk("t4_partial", rt1, 32'h02);
        nd = 0;
        for (int n = 0; n < 12; n++) begin
            if (done1) nd++;
            @(negedge clk);
        end
        chk("t4_no_done", nd, 32'd0);
        chk("t4_pass", pass1, 32'd0);
        run_sweep(l1, l0, seq);
        chk("t4_restart_lat", l1, 32'd8);
        chk("t4_restart_pass", pass1, 32'd1);
        repeat (2) @(negedge clk);

        // 5: reset mid-sweep
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_busy", busy1, 32'd0);
        chk("t5_vec", v1, 32'd0);
        chk("t5_result", rt1, 32'd0);
        chk("t5_err", ec1, 32'd0);
        chk("t5_result0", rt0, 32'd0);
        chk("t5_busy0", busy0, 32'd0);
        run_sweep(l1, l0, seq);
        chk("t5_lat", l1, 32'd8);
        chk("t5_after", rt1, 32'hB2);
        repeat (2) @(negedge clk);

        // randomized traffic, checked by the per-cycle model
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 99) < 20);
            abort = ($urandom_range(0, 99) < 3);
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 2))
                    0: exp_table = 8'hB2;
                    1: exp_table = 8'($urandom);
                    default: exp_table = 8'hB2 ^ (8'h01 << $urandom_range(0, 7));
                endcase
            end
        end
        start = 1'b0; abort = 1'b0; reset = 1'b0;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
